// File: rtl/vxe_txnreq_arbiter.sv
// rtl/vxe_txnreq_arbiter.sv - two-client memory request arbiter with packed output slot and credit limit
// Optional feature macro: VXE_TXNREQ_ARB_FIXED_PRIO_EN (client 0 always wins contention; no RR pointer)
module vxe_txnreq_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_c0_valid,
  output logic        o_c0_ready,
  input  logic [4:0]  i_c0_txnid,
  input  logic        i_c0_rnw,
  input  logic [36:0] i_c0_addr,
  input  logic [63:0] i_c0_data,
  input  logic [7:0]  i_c0_ben,
  input  logic        i_c1_valid,
  output logic        o_c1_ready,
  input  logic [4:0]  i_c1_txnid,
  input  logic        i_c1_rnw,
  input  logic [36:0] i_c1_addr,
  input  logic [63:0] i_c1_data,
  input  logic [7:0]  i_c1_ben,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic [43:0] o_req_vec_txn,
  output logic [71:0] o_req_vec_dat,
  input  logic        i_rsp_done,
  output logic        o_busy
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [43:0]      txn_q, txn_d;
  logic [71:0]      dat_q, dat_d;
  logic             can_accept;
  logic             grant;
  logic             win;

  // Slot can take a new request if it is free or draining this cycle, and credits remain
  assign can_accept = ((state_q == ST_EMPTY) | i_req_ready) &
                      (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign grant      = can_accept & (i_c0_valid | i_c1_valid);

`ifdef VXE_TXNREQ_ARB_FIXED_PRIO_EN
  // Winner select: client 0 has fixed priority under contention
  always_comb begin
    win = 1'b0;
    if (!i_c0_valid && i_c1_valid) win = 1'b1;
  end
`else
  logic ptr_q, ptr_d;

  // Winner select: under contention the client that did not win last time goes
  always_comb begin
    win = 1'b0;
    if (i_c0_valid && i_c1_valid) win = ~ptr_q;
    else if (i_c1_valid)          win = 1'b1;
  end

  // Pointer remembers the most recent winner
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = win;
  end

  // Pointer register; reset value 1 lets client 0 win the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
`endif

  assign o_c0_ready = grant & ~win;
  assign o_c1_ready = grant &  win;

  // Pack the winning request, tagging the txnid MSB with the client number
  always_comb begin
    txn_d = txn_q;
    dat_d = dat_q;
    if (grant) begin
      if (win) begin
        txn_d = {1'b1, i_c1_txnid, i_c1_rnw, i_c1_addr};
        dat_d = {i_c1_ben, i_c1_data};
      end else begin
        txn_d = {1'b0, i_c0_txnid, i_c0_rnw, i_c0_addr};
        dat_d = {i_c0_ben, i_c0_data};
      end
    end
  end

  // Credit counter: grant takes a credit, retirement returns one, both cancel
  always_comb begin
    cnt_d = cnt_q;
    if (grant && !i_rsp_done)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!grant && i_rsp_done && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Slot FSM next state: reload on grant, drain on downstream handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (!grant && i_req_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Slot FSM, payload and credit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      txn_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot FSM outputs
  always_comb begin
    o_req_valid   = (state_q == ST_FULL);
    o_req_vec_txn = txn_q;
    o_req_vec_dat = dat_q;
    o_busy        = (state_q == ST_FULL) | (cnt_q != '0);
  end

endmodule
